inst_mem_arbiter: RTL
=====================

Name: inst_mem_arbiter

Overview:
- Two-requester arbiter in front of the single-port on-chip instruction RAM (16384 x 32, byte-enabled, 1-cycle read latency).
- Shares the RAM between the CPU instruction-fetch master (read-only) and the program-loader master (read/write, fed from the FIFO path).
- Round-robin with a bounded hold window, so a streaming loader cannot starve fetch and fetch cannot starve the loader.
- Generates per-port waitrequest and readdatavalid.

Parameters:
- ADDR_W, 14, RAM word-address width
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- MAX_HOLD, 4, max consecutive grants to one port while the other is requesting (1..15)

Ports:
- clk  in  1  single clock
- reset_n  in  1  synchronous, active-low reset
- cpu_address  in  ADDR_W  fetch word address
- cpu_read  in  1  fetch request
- cpu_waitrequest  out  1  high = request not accepted this cycle
- cpu_readdata  out  DATA_W  fetch data
- cpu_readdatavalid  out  1  cpu_readdata valid
- ldr_address  in  ADDR_W  loader word address
- ldr_read  in  1  loader read request
- ldr_write  in  1  loader write request (read and write never both high)
- ldr_byteenable  in  BE_W  write byte lanes
- ldr_writedata  in  DATA_W  write data
- ldr_waitrequest  out  1  high = not accepted
- ldr_readdata  out  DATA_W  loader read data
- ldr_readdatavalid  out  1  ldr_readdata valid
- ram_address  out  ADDR_W  to RAM
- ram_byteenable  out  BE_W  to RAM
- ram_writedata  out  DATA_W  to RAM
- ram_chipselect  out  1  to RAM
- ram_write  out  1  to RAM
- ram_clken  out  1  RAM clock enable
- ram_readdata  in  DATA_W  RAM q, valid one cycle after address

Behaviour:
- Reset (reset_n low at a clk edge):
  - owner=NONE, hold_cnt=0, rd_tag=NONE, last=LDR (so CPU wins the first tie).
  - Outputs: both waitrequest=1, both readdatavalid=0, readdata=0, ram_chipselect=0, ram_write=0, ram_clken=0.
  - ram_clken=1 on every cycle after reset is released.
  - Reset mid-read discards the in-flight read: no readdatavalid after reset.
- Request signals: req_cpu=cpu_read; req_ldr=ldr_read|ldr_write.
- Grant is combinational from the current requests and registered state (owner, hold_cnt, last). Exactly one port is granted per cycle, or none.
  - Only one port requesting: that port is granted.
  - Both requesting, owner=NONE: grant the port opposite to last.
  - Both requesting, owner=X and hold_cnt<MAX_HOLD: grant X.
  - Both requesting, owner=X and hold_cnt==MAX_HOLD: grant the other port.
- Granted port: waitrequest=0 this cycle. RAM signals are driven from that port's signals with ram_chipselect=1.
  - ram_write=ldr_write only when the loader is granted.
  - CPU grant drives ram_byteenable=all ones.
- Non-granted requesting port: waitrequest=1. Its master holds its signals stable (Avalon rule).
- Idle port (no request): waitrequest=1. No grant, ram_chipselect=0.
- State update at each edge:
  - Grant to the same port as owner: hold_cnt++, saturating at MAX_HOLD.
  - Grant to a new port: owner=that port, hold_cnt=1, last=that port.
  - No grant: owner=NONE, hold_cnt=0.
- Read pipeline:
  - An accepted read sets rd_tag=port at the edge, otherwise rd_tag=NONE.
  - Next cycle: readdatavalid=1 for the rd_tag port with readdata=ram_readdata.
  - Back-to-back reads from one port give one result per cycle.
  - Interleaved reads keep the order of issue.
- Writes are posted: no response, 1-cycle occupancy.
- Ordering: a read issued the cycle after a write to the same address returns the new data. A write and a read can never be issued in the same cycle.

Decomposition:
- Shared package inst_mem_pkg: owner_t enum {OWN_NONE, OWN_CPU, OWN_LDR}, ADDR_W/DATA_W/BE_W constants, MEM_WORDS=16384.
- Sub-module rr_hold_arb: 2-way round-robin with hold counter, pure grant logic plus state. The mux and read-tag logic stay in the top module.

Test Plan:
- CPU reads 0x0000..0x0003 alone -> waitrequest 0 every cycle; 4 readdatavalid pulses one cycle after each address, data matching the init image.
- Both requesting continuously, MAX_HOLD=4, CPU wins first -> grant pattern CPU x4, LDR x4, CPU x4...; neither port waits more than 4 cycles.
- Loader writes 0xDEADBEEF to 0x0100 with byteenable=0xF; CPU reads 0x0100 the next cycle -> cpu_readdata=0xDEADBEEF.
- Loader write with byteenable=0x2, data 0x0000AB00, over 0x11223344 -> RAM word becomes 0x1122AB44.
- CPU and loader reads alternate, CPU requests at t, loader at t+1 -> readdatavalid CPU at t+1, LDR at t+2, each with its own address's data.
- reset_n low in the cycle after an accepted CPU read -> no cpu_readdatavalid; all outputs at reset values. After release, the first tie is granted to the CPU.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared types and sizes for the instruction RAM arbiter
// Provides owner_t (which port holds or last held the RAM) and the default
// geometry of the 16384 x 32 byte-enabled instruction RAM.
package inst_mem_pkg;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int MEM_WORDS = 16384;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } owner_t;

endpackage

// File: rtl/inst_mem_arbiter_rr_hold_arb.sv
// rtl/inst_mem_arbiter_rr_hold_arb.sv - two-way round-robin arbiter with bounded hold
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   req_cpu, req_ldr   requests from the fetch and loader ports
//   gnt_cpu, gnt_ldr   combinational one-hot (or zero) grant
// The current owner keeps the RAM while the other port waits, for at most
// MAX_HOLD consecutive grants; then ownership swaps.
module rr_hold_arb #(
  parameter int MAX_HOLD = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req_cpu,
  input  logic req_ldr,
  output logic gnt_cpu,
  output logic gnt_ldr
);
  import inst_mem_pkg::*;

  localparam int CNT_W = 4;

  owner_t             owner_q;
  owner_t             last_q;
  owner_t             gnt;
  logic [CNT_W-1:0]   hold_q;

  // Grant decision; nothing is granted while reset is asserted so no
  // access can slip into the RAM during the reset cycle.
  always_comb begin
    gnt = OWN_NONE;
    if (!reset_n) begin
      gnt = OWN_NONE;
    end else if (req_cpu && !req_ldr) begin
      gnt = OWN_CPU;
    end else if (req_ldr && !req_cpu) begin
      gnt = OWN_LDR;
    end else if (req_cpu && req_ldr) begin
      if (owner_q == OWN_NONE) begin
        // Fresh contention: the port that did not win last time goes first.
        gnt = (last_q == OWN_CPU) ? OWN_LDR : OWN_CPU;
      end else if (hold_q < CNT_W'(MAX_HOLD)) begin
        gnt = owner_q;
      end else begin
        gnt = (owner_q == OWN_CPU) ? OWN_LDR : OWN_CPU;
      end
    end
  end

  assign gnt_cpu = (gnt == OWN_CPU);
  assign gnt_ldr = (gnt == OWN_LDR);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner_q <= OWN_NONE;
      hold_q  <= '0;
      last_q  <= OWN_LDR;
    end else if (gnt == OWN_NONE) begin
      owner_q <= OWN_NONE;
      hold_q  <= '0;
    end else if (gnt == owner_q) begin
      if (hold_q < CNT_W'(MAX_HOLD)) begin
        hold_q <= hold_q + 4'd1;
      end
    end else begin
      owner_q <= gnt;
      hold_q  <= 4'd1;
      last_q  <= gnt;
    end
  end

endmodule

// File: rtl/inst_mem_arbiter.sv
// rtl/inst_mem_arbiter.sv - shares the single-port instruction RAM between fetch and loader
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   cpu_*                     read-only fetch master (address/read/waitrequest/readdata/readdatavalid)
//   ldr_*                     read/write program-loader master
//   ram_*                     single-port RAM, 1-cycle read latency
// One port is granted per cycle. Reads return one cycle after acceptance on
// the port that issued them; writes are posted.
module inst_mem_arbiter #(
  parameter int ADDR_W   = inst_mem_pkg::ADDR_W,
  parameter int DATA_W   = inst_mem_pkg::DATA_W,
  parameter int BE_W     = inst_mem_pkg::BE_W,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_readdatavalid,
  input  logic [ADDR_W-1:0] ldr_address,
  input  logic              ldr_read,
  input  logic              ldr_write,
  input  logic [BE_W-1:0]   ldr_byteenable,
  input  logic [DATA_W-1:0] ldr_writedata,
  output logic              ldr_waitrequest,
  output logic [DATA_W-1:0] ldr_readdata,
  output logic              ldr_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);
  import inst_mem_pkg::*;

  logic   gnt_cpu;
  logic   gnt_ldr;
  owner_t rd_tag;

  rr_hold_arb #(
    .MAX_HOLD (MAX_HOLD)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_cpu (cpu_read),
    .req_ldr (ldr_read | ldr_write),
    .gnt_cpu (gnt_cpu),
    .gnt_ldr (gnt_ldr)
  );

  assign cpu_waitrequest = ~gnt_cpu;
  assign ldr_waitrequest = ~gnt_ldr;

  assign ram_chipselect = gnt_cpu | gnt_ldr;
  assign ram_write      = gnt_ldr & ldr_write;
  assign ram_address    = gnt_ldr ? ldr_address : cpu_address;
  assign ram_byteenable = gnt_ldr ? ldr_byteenable : '1;
  assign ram_writedata  = ldr_writedata;
  assign ram_clken      = reset_n;

  // Remembers which port's read is in the RAM pipeline this cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_tag <= OWN_NONE;
    end else if (gnt_cpu) begin
      rd_tag <= OWN_CPU;
    end else if (gnt_ldr && ldr_read) begin
      rd_tag <= OWN_LDR;
    end else begin
      rd_tag <= OWN_NONE;
    end
  end

  // Qualified by reset_n so a read caught by reset never reports back.
  assign cpu_readdatavalid = reset_n && (rd_tag == OWN_CPU);
  assign ldr_readdatavalid = reset_n && (rd_tag == OWN_LDR);
  assign cpu_readdata      = cpu_readdatavalid ? ram_readdata : '0;
  assign ldr_readdata      = ldr_readdatavalid ? ram_readdata : '0;

endmodule
